// File: rtl/fetch_decoder.sv
// Instruction fetch decoder: a FIFO of 64-bit words, each holding two instructions, feeding a registered decode stage.
// Build option FETCH_DECODER_BESM6_EN adds per-word BESM-6 format decode selected by in_pe.
`timescale 1ns/1ps

module fetch_decoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_word,
  input  logic                       in_pe,
  input  logic                       in_right,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 ir,
  output logic [7:0]                 op,
  output logic                       extop,
  output logic [ADDR_W-1:0]          addr,
  output logic                       out_tkk,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high.
  logic [63:0]   word_mem  [DEPTH];
  logic          right_mem [DEPTH];
`ifdef FETCH_DECODER_BESM6_EN
  logic          pe_mem    [DEPTH];
`else
  logic          unused_pe;
  assign unused_pe = in_pe;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          half_q, half_d;
  logic          valid_q, valid_d;
  logic [3:0]    ir_q, ir_d;
  logic [7:0]    op_q, op_d;
  logic          extop_q, extop_d;
  logic [19:0]   addr_q, addr_d;
  logic          tkk_q, tkk_d;

  logic [63:0]   head_word;
  logic          head_right;
  logic          head_pe;
  logic          eff_h;
  logic          push;
  logic          load;
  logic          pop;

  logic [31:0]   nat_h;
  logic [3:0]    dec_ir;
  logic [7:0]    dec_op;
  logic          dec_extop;
  logic [19:0]   dec_addr;

  assign head_word  = word_mem[rd_ptr_q];
  assign head_right = right_mem[rd_ptr_q];
`ifdef FETCH_DECODER_BESM6_EN
  assign head_pe    = pe_mem[rd_ptr_q];
`else
  assign head_pe    = 1'b0;
`endif

  // half_q marks a head whose left half is already emitted; otherwise the entry's own flag picks the half.
  assign eff_h    = half_q | head_right;
  assign in_ready = (count_q < DEPTH_C) && !flush;
  assign push     = in_valid && in_ready;
  assign load     = (!valid_q || out_ready) && (count_q != '0);
  assign pop      = load && eff_h;

  always_comb begin
    nat_h     = eff_h ? head_word[31:0] : head_word[63:32];
    dec_ir    = nat_h[31:28];
    dec_op    = nat_h[27:20];
    dec_extop = 1'b0;
    dec_addr  = nat_h[19:0];
    if (nat_h[27:20] == 8'h3F) begin
      dec_extop = 1'b1;
      dec_op    = nat_h[19:12];
      dec_addr  = {8'h00, nat_h[11:0]};
    end
`ifdef FETCH_DECODER_BESM6_EN
    if (head_pe) begin
      logic [23:0] besm_h;
      besm_h = eff_h ? head_word[23:0] : head_word[47:24];
      dec_ir = besm_h[23:20];
      if (besm_h[19]) begin
        dec_extop = 1'b1;
        dec_op    = {4'b0000, besm_h[18:15]};
        dec_addr  = {5'b00000, besm_h[14:0]};
      end else begin
        dec_extop = 1'b0;
        dec_op    = {2'b00, besm_h[17:12]};
        dec_addr  = {8'h00, besm_h[11:0]};
      end
    end
`else
    if (head_pe) begin
      dec_extop = dec_extop;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    half_d   = half_q;
    valid_d  = valid_q;
    ir_d     = ir_q;
    op_d     = op_q;
    extop_d  = extop_q;
    addr_d   = addr_q;
    tkk_d    = tkk_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      half_d   = 1'b0;
      valid_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (load) begin
        valid_d = 1'b1;
        half_d  = !eff_h;
        ir_d    = dec_ir;
        op_d    = dec_op;
        extop_d = dec_extop;
        addr_d  = dec_addr;
        tkk_d   = eff_h;
      end else if (out_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
      valid_q  <= 1'b0;
      ir_q     <= '0;
      op_q     <= '0;
      extop_q  <= 1'b0;
      addr_q   <= '0;
      tkk_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
      valid_q  <= valid_d;
      ir_q     <= ir_d;
      op_q     <= op_d;
      extop_q  <= extop_d;
      addr_q   <= addr_d;
      tkk_q    <= tkk_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q]  <= in_word;
      right_mem[wr_ptr_q] <= in_right;
`ifdef FETCH_DECODER_BESM6_EN
      pe_mem[wr_ptr_q]    <= in_pe;
`endif
    end
  end

  assign out_valid = valid_q;
  assign ir        = ir_q;
  assign op        = op_q;
  assign extop     = extop_q;
  assign addr      = ADDR_W'(addr_q);
  assign out_tkk   = tkk_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_decoder.sv
// Self-checking bench for fetch_decoder: directed cases plus randomized traffic against an expected-instruction queue.
`timescale 1ns/1ps

module tb_fetch_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_word;
  logic        in_pe;
  logic        in_right;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ir;
  logic [7:0]  op;
  logic        extop;
  logic [19:0] addr;
  logic        out_tkk;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int burst_n = 0;
  int burst_first = 0;
  int burst_last = 0;
  logic rand_rdy = 1'b0;

  // Record layout: {ir[3:0], op[7:0], extop, addr[19:0], tkk}
  logic [33:0] exp_q[$];
  logic [33:0] held;
  logic        held_v = 1'b0;

  fetch_decoder dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_pe(in_pe), .in_right(in_right),
    .out_valid(out_valid), .out_ready(out_ready),
    .ir(ir), .op(op), .extop(extop), .addr(addr),
    .out_tkk(out_tkk), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] ref_dec(input logic [63:0] w, input logic pe, input logic half);
    logic [31:0] h;
    logic [23:0] b;
    logic        use_besm;
`ifdef FETCH_DECODER_BESM6_EN
    use_besm = pe;
`else
    use_besm = pe & 1'b0;
`endif
    if (use_besm) begin
      b = half ? w[23:0] : w[47:24];
      if (b[19] == 1'b0) return {b[23:20], 2'b00, b[17:12], 1'b0, 8'h00, b[11:0], half};
      else               return {b[23:20], 4'h0, b[18:15], 1'b1, 5'h00, b[14:0], half};
    end
    h = half ? w[31:0] : w[63:32];
    if (h[27:20] == 8'h3F) return {h[31:28], h[19:12], 1'b1, 8'h00, h[11:0], half};
    return {h[31:28], h[27:20], 1'b0, h[19:0], half};
  endfunction

  // Output monitor: compares every accepted instruction and checks stability during stalls.
  always @(negedge clk) begin
    logic [33:0] cur;
    logic [33:0] e;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      cur = {ir, op, extop, addr, out_tkk};
      if (held_v && out_valid) check("hold_stable", 64'(cur), 64'(held));
      held_v = out_valid && !out_ready;
      held   = cur;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(cur), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("instr", 64'(cur), 64'(e));
        end
        if (burst_n == 0) burst_first = cyc;
        burst_last = cyc;
        burst_n++;
      end
    end
  end

  task automatic send(input logic [63:0] w, input logic pe, input logic r);
    int n;
    n = 0;
    in_word = w; in_pe = pe; in_right = r; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_auto(input logic [63:0] w, input logic pe, input logic r);
    if (!r) exp_q.push_back(ref_dec(w, pe, 1'b0));
    exp_q.push_back(ref_dec(w, pe, 1'b1));
    send(w, pe, r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_fields"}, 64'({ir, op, extop, addr, out_tkk}), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = '0;
    in_pe = 1'b0; in_right = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;

    // Native word: left then right half
    exp_q.push_back({4'h5, 8'hA1, 1'b0, 20'hABCDE, 1'b0});
    exp_q.push_back({4'h7, 8'h9A, 1'b1, 20'h00123, 1'b1});
    send(64'h5A1ABCDE73F9A123, 1'b0, 1'b0);
    drain();

    // BESM-6 flagged word
`ifdef FETCH_DECODER_BESM6_EN
    exp_q.push_back({4'h3, 8'h05, 1'b0, 20'h00789, 1'b0});
    exp_q.push_back({4'hA, 8'h08, 1'b1, 20'h01234, 1'b1});
`else
    exp_q.push_back({4'h0, 8'h00, 1'b0, 20'h03057, 1'b0});
    exp_q.push_back({4'h8, 8'h9A, 1'b0, 20'hC1234, 1'b1});
`endif
    send(64'h0000305789AC1234, 1'b1, 1'b0);
    drain();

    // Right-only word: single output, head popped on load
    out_ready = 1'b0;
    exp_q.push_back({4'h7, 8'h9A, 1'b1, 20'h00123, 1'b1});
    send(64'h5A1ABCDE73F9A123, 1'b0, 1'b1);
    @(negedge clk);
    check("right_count_before", 64'(count), 64'd1);
    @(negedge clk);
    check("right_count_after", 64'(count), 64'd0);
    check("right_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("right_no_more", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Fill to DEPTH with consumer stalled, then release
    out_ready = 1'b0;
    burst_n = 0;
    for (int i = 0; i < 4; i++) send_auto({8'h10 + 8'(i), 24'h3F0000 + 24'(i), 32'h2A012345 + 32'(i)}, 1'b0, 1'b0);
    @(negedge clk);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    fork
      send_auto(64'h9876543210FEDCBA, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("full_hold_count", 64'(count), 64'd4);
        check("full_hold_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    check("burst_n", 64'(burst_n), 64'd10);
    check("burst_span", 64'(burst_last - burst_first), 64'd9);

    // Flush with 3 words held, output pending and a word offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_auto({32'h11223344 + 32'(i), 32'h55667788}, 1'b0, 1'b0);
    @(negedge clk);
    check("preflush_count", 64'(count), 64'd3);
    check("preflush_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_word = 64'hDEADBEEFCAFEF00D; in_right = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("flush_dropped_count", 64'(count), 64'd0);
    check("flush_dropped_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset mid-operation, then latency of the next word
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send_auto({32'hA0B0C0D0, 32'h01020304 + 32'(i)}, 1'b0, 1'b0);
    @(negedge clk);
    check("prereset_count", 64'(count), 64'd2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_zero_outputs("midreset");
    @(posedge clk); #1 out_ready = 1'b1;
    send_auto(64'h4C2F00017BBB0002, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_n", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_n1", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain();

    // Random traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [63:0] w;
      w = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) w[59:52] = 8'h3F;
      if ($urandom_range(0, 3) == 0) w[27:20] = 8'h3F;
      send_auto(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    check("end_count", 64'(count), 64'd0);
    check("end_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
